// File: rtl/bin_to_bcd7.sv
// Sequential 24-bit binary to 7-digit packed BCD converter (double dabble, one bit per clock).
// Optional macro BCD_SATURATE_EN clamps out-of-range results to 9999999 and raises ovf.
module bin_to_bcd7 (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] bin,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [27:0] bcd,
   output logic        ovf
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [4:0]  r_cnt;
   logic [23:0] r_bin;
   logic [31:0] r_scratch;
   logic [27:0] r_bcd;
   logic        r_done;
   logic [31:0] w_stepped;
   logic [27:0] w_result;
   logic        w_last;

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [31:0] dabbleStep(input logic [31:0] s, input logic b);
      logic [31:0] a;
      for (int d = 0; d < 8; d++) begin
         a[4*d +: 4] = (s[4*d +: 4] >= 4'd5) ? (s[4*d +: 4] + 4'd3) : s[4*d +: 4];
      end
      return {a[30:0], b};
   endfunction

   assign w_stepped = dabbleStep(r_scratch, r_bin[23]);
   assign w_last    = (r_state == SHIFT) && (r_cnt == 5'd23);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == 5'd23) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= 5'd0;
         r_bin     <= 24'd0;
         r_scratch <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bin     <= bin;
                  r_scratch <= 32'd0;
                  r_cnt     <= 5'd0;
               end
            end
            SHIFT: begin
               r_bin     <= {r_bin[22:0], 1'b0};
               r_scratch <= w_stepped;
               r_cnt     <= r_cnt + 5'd1;
            end
            default: begin
               r_cnt <= 5'd0;
            end
         endcase
      end
   end

`ifdef BCD_SATURATE_EN
   logic r_ovf;
   logic w_over;

   // A nonzero eighth digit means the value is at least 10,000,000.
   assign w_over   = (w_stepped[31:28] != 4'd0);
   assign w_result = w_over ? 28'h9999999 : w_stepped[27:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= w_over;
      end
   end

   assign ovf = r_ovf;
`else
   assign w_result = w_stepped[27:0];
   assign ovf      = 1'b0;
`endif

   // The whole digit set is loaded on a single edge so the display never sees a partial result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcd  <= 28'h0000000;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last) begin
            r_bcd <= w_result;
         end
      end
   end

   assign busy = (r_state == SHIFT);
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd7.sv
// Self-checking bench for bin_to_bcd7: directed scenarios plus random values against an arithmetic model.
// Honours BCD_SATURATE_EN the same way as the design.
module tb_bin_to_bcd7;

   logic        clk;
   logic        rst;
   logic [23:0] bin;
   logic        start;
   logic        busy;
   logic        done;
   logic [27:0] bcd;
   logic        ovf;

   int nVec;
   int nErr;

   bin_to_bcd7 dut (
      .clk   (clk),
      .rst   (rst),
      .bin   (bin),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result: decimal digits of the value, clamped or wrapped at seven digits.
   function automatic logic [27:0] modelBcd(input int unsigned v);
      logic [27:0] r;
      int unsigned x;
      r = 28'h0;
`ifdef BCD_SATURATE_EN
      if (v > 9999999) return 28'h9999999;
`endif
      x = v % 10000000;
      for (int d = 0; d < 7; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic modelOvf(input int unsigned v);
`ifdef BCD_SATURATE_EN
      return (v > 9999999);
`else
      return (v > 16777215);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag, input logic [27:0] expBcd);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_bcd"},  {4'd0, bcd}, {4'd0, expBcd});
   endtask

   // Presents a one-cycle start; the accepting edge is the tick inside this task.
   task automatic applyStimulus(input logic [23:0] v);
      start = 1'b1;
      bin   = v;
      tick();
      start = 1'b0;
      bin   = 24'($urandom);
   endtask

   // Runs one conversion, checking busy/done each cycle; optionally injects a start at shift ignoreAt.
   task automatic convertCheck(input logic [23:0] v, input int ignoreAt, input logic [23:0] ignoreVal);
      logic [27:0] prevBcd;
      prevBcd = bcd;
      applyStimulus(v);
      checkOutput("accept_busy", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= 24; i++) begin
         if (i == ignoreAt) begin
            start = 1'b1;
            bin   = ignoreVal;
         end else begin
            start = 1'b0;
            bin   = 24'($urandom);
         end
         tick();
         if (i < 24) begin
            checkOutput("shift_busy", {31'd0, busy}, 32'd1);
            checkOutput("shift_done", {31'd0, done}, 32'd0);
            checkOutput("shift_hold", {4'd0, bcd}, {4'd0, prevBcd});
         end else begin
            checkOutput("end_busy", {31'd0, busy}, 32'd0);
            checkOutput("end_done", {31'd0, done}, 32'd1);
            checkOutput("end_bcd",  {4'd0, bcd}, {4'd0, modelBcd(32'(v))});
            checkOutput("end_ovf",  {31'd0, ovf}, {31'd0, modelOvf(32'(v))});
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic [23:0] rv;
      nVec  = 0;
      nErr  = 0;
      rst   = 1'b0;
      start = 1'b0;
      bin   = 24'd0;

      tick();
      tick();
      checkIdle("reset", 28'h0);
      checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      $display("[TB] scenario 1: zero");
      convertCheck(24'd0, 0, 24'd0);
      checkOutput("s1_bcd", {4'd0, bcd}, 32'h0000000);

      $display("[TB] scenario 2: 1234567");
      tick();
      convertCheck(24'd1234567, 0, 24'd0);
      checkOutput("s2_bcd", {4'd0, bcd}, 32'h1234567);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkIdle("s2_hold", 28'h1234567);
      end

      $display("[TB] scenario 3: 9999999");
      convertCheck(24'd9999999, 0, 24'd0);
      checkOutput("s3_bcd", {4'd0, bcd}, 32'h9999999);
      checkOutput("s3_ovf", {31'd0, ovf}, 32'd0);

      $display("[TB] scenario 4: 16777215 and 10000000");
      tick();
      convertCheck(24'd16777215, 0, 24'd0);
`ifdef BCD_SATURATE_EN
      checkOutput("s4_bcd", {4'd0, bcd}, 32'h9999999);
      checkOutput("s4_ovf", {31'd0, ovf}, 32'd1);
`else
      checkOutput("s4_bcd", {4'd0, bcd}, 32'h6777215);
      checkOutput("s4_ovf", {31'd0, ovf}, 32'd0);
`endif
      tick();
      convertCheck(24'd10000000, 0, 24'd0);

      $display("[TB] scenario 5: ignored start and back-to-back");
      tick();
      convertCheck(24'd42, 5, 24'd555);
      checkOutput("s5_first", {4'd0, bcd}, 32'h0000042);
      convertCheck(24'd555, 0, 24'd0);
      checkOutput("s5_second", {4'd0, bcd}, 32'h0000555);

      $display("[TB] scenario 6: reset during shift");
      tick();
      applyStimulus(24'd7654321);
      for (int i = 1; i <= 10; i++) begin
         tick();
      end
      checkOutput("s6_busy_before", {31'd0, busy}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      checkIdle("s6_async", 28'h0);
      checkOutput("s6_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checkIdle("s6_nodone", 28'h0);
      end
      convertCheck(24'd7654321, 0, 24'd0);
      checkOutput("s6_bcd", {4'd0, bcd}, 32'h7654321);

      $display("[TB] random conversions");
      for (int n = 0; n < 16; n++) begin
         rv = 24'($urandom_range(0, 24'hFFFFFF));
         if (n % 4 == 3) begin
            rv = 24'($urandom_range(0, 9999999));
         end
         convertCheck(rv, (n % 3 == 0) ? int'($urandom_range(1, 23)) : 0, 24'($urandom));
      end
      tick();
      checkOutput("final_done", {31'd0, done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
